// File: rtl/div_operand_normalizer.sv
// Operand normalizer ahead of the Goldschmidt divider: left-justifies N and D one bit per
// cycle, reporting shift counts, zero flags and the initial-approximation select.
module div_operand_normalizer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] n_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] n_norm,
    output logic [WIDTH-1:0] d_norm,
    output logic [CNT_W-1:0] shift_n,
    output logic [CNT_W-1:0] shift_d,
    output logic             n_zero,
    output logic             div_by_zero,
    output logic [1:0]       ia_sel
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } stateType;

    stateType state;
    logic     nDone;
    logic     dDone;

    // An operand is finished once its MSB is set; a zero operand never gets there and
    // is treated as finished immediately, which also keeps the counters from wrapping.
    always_comb begin
        nDone = n_norm[WIDTH-1] || (n_norm == '0);
        dDone = d_norm[WIDTH-1] || (d_norm == '0);
    end

    assign in_ready = (state == IDLE) && !reset;
    assign ia_sel   = div_by_zero ? 2'b00 : d_norm[WIDTH-2:WIDTH-3];

    // NOTE: every register here is sequential state, so all updates use non-blocking
    // assignments; blocking ones would let later statements see same-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            n_norm      <= '0;
            d_norm      <= '0;
            shift_n     <= '0;
            shift_d     <= '0;
            n_zero      <= 1'b0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        n_norm      <= n_in;
                        d_norm      <= d_in;
                        shift_n     <= '0;
                        shift_d     <= '0;
                        n_zero      <= (n_in == '0);
                        div_by_zero <= (d_in == '0);
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The edge that sees both operands finished only advances the state.
                    if (nDone && dDone) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (!nDone) begin
                            n_norm  <= n_norm << 1;
                            shift_n <= shift_n + CNT_W'(1);
                        end
                        if (!dDone) begin
                            d_norm  <= d_norm << 1;
                            shift_d <= shift_d + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_operand_normalizer.sv
// Directed-vector bench for div_operand_normalizer: hand-computed results, latencies,
// back-pressure hold, mid-operation reset and zero-operand corners.
module tb_div_operand_normalizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] n_in;
    logic [15:0] d_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] n_norm;
    logic [15:0] d_norm;
    logic [3:0]  shift_n;
    logic [3:0]  shift_d;
    logic        n_zero;
    logic        div_by_zero;
    logic [1:0]  ia_sel;

    int assertCount = 0;
    int failCount   = 0;
    int lat;
    logic [43:0] got;
    logic [43:0] exp;

    div_operand_normalizer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .n_in(n_in),
        .d_in(d_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .n_norm(n_norm),
        .d_norm(d_norm),
        .shift_n(shift_n),
        .shift_d(shift_d),
        .n_zero(n_zero),
        .div_by_zero(div_by_zero),
        .ia_sel(ia_sel)
    );

    always #5 clk = ~clk;

    // Result bundle: n_norm, d_norm, shift_n, shift_d, n_zero, div_by_zero, ia_sel.
    always_comb got = {n_norm, d_norm, shift_n, shift_d, n_zero, div_by_zero, ia_sel};

    task automatic accept_op(input logic [15:0] n, input logic [15:0] d);
        n_in     = n;
        d_in     = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Edges from the accept edge until out_valid is seen; -1 if the bound expires.
    task automatic wait_out(output int edges);
        int i;
        edges = -1;
        i = 0;
        while (edges < 0 && i < 40) begin
            @(posedge clk);
            #1;
            i++;
            if (out_valid) edges = i;
        end
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        assertCount++;
        if (got !== 44'd0 || out_valid !== 1'b0) begin
            failCount++;
            $display("FAIL reset_outputs: got %h valid %b, want 0 valid 0", got, out_valid);
        end
        assertCount++;
        if (in_ready !== 1'b0) begin
            failCount++;
            $display("FAIL reset_in_ready: got %b, want 0", in_ready);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        assertCount++;
        if (in_ready !== 1'b1) begin
            failCount++;
            $display("FAIL idle_in_ready: got %b, want 1", in_ready);
        end
        @(posedge clk);
        #1;
        assertCount++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failCount++;
            $display("FAIL idle_quiet: valid %b ready %b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        accept_op(16'h4000, 16'h6000);
        wait_out(lat);
        exp = {16'h8000, 16'hC000, 4'd1, 4'd1, 1'b0, 1'b0, 2'b10};
        assertCount++;
        if (lat !== 2) begin
            failCount++;
            $display("FAIL basic_latency: got %0d, want 2", lat);
        end
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL basic_result: got %h, want %h", got, exp);
        end
        deliver();
        assertCount++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failCount++;
            $display("FAIL basic_handshake: valid %b ready %b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_max_shift();
        accept_op(16'h00FF, 16'h0001);
        wait_out(lat);
        exp = {16'hFF00, 16'h8000, 4'd8, 4'd15, 1'b0, 1'b0, 2'b00};
        assertCount++;
        if (lat !== 16) begin
            failCount++;
            $display("FAIL max_latency: got %0d, want 16", lat);
        end
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL max_result: got %h, want %h", got, exp);
        end
        deliver();
    endtask

    task automatic test_div_zero();
        accept_op(16'h1234, 16'h0000);
        wait_out(lat);
        exp = {16'h91A0, 16'h0000, 4'd3, 4'd0, 1'b0, 1'b1, 2'b00};
        assertCount++;
        if (lat !== 4) begin
            failCount++;
            $display("FAIL dz_latency: got %0d, want 4", lat);
        end
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL dz_result: got %h, want %h", got, exp);
        end
        deliver();
    endtask

    task automatic test_back_pressure();
        accept_op(16'h8000, 16'hFFFF);
        wait_out(lat);
        exp = {16'h8000, 16'hFFFF, 4'd0, 4'd0, 1'b0, 1'b0, 2'b11};
        assertCount++;
        if (lat !== 1) begin
            failCount++;
            $display("FAIL bp_latency: got %0d, want 1", lat);
        end
        n_in     = 16'h0001;
        d_in     = 16'h0001;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            assertCount++;
            if (got !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failCount++;
                $display("FAIL bp_hold%0d: got %h valid %b ready %b, want %h 1 0",
                         i, got, out_valid, in_ready, exp);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        deliver();
        assertCount++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failCount++;
            $display("FAIL bp_release: valid %b ready %b, want 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        assertCount++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failCount++;
            $display("FAIL bp_single: valid %b ready %b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_abort();
        accept_op(16'h0001, 16'h0010);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        assertCount++;
        if (got !== 44'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failCount++;
            $display("FAIL abort_clear: got %h valid %b ready %b, want 0 0 0",
                     got, out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        assertCount++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failCount++;
            $display("FAIL abort_idle: valid %b ready %b, want 0 1", out_valid, in_ready);
        end
        accept_op(16'h0001, 16'h0001);
        wait_out(lat);
        exp = {16'h8000, 16'h8000, 4'd15, 4'd15, 1'b0, 1'b0, 2'b00};
        assertCount++;
        if (lat !== 16) begin
            failCount++;
            $display("FAIL abort_next_latency: got %0d, want 16", lat);
        end
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL abort_next_result: got %h, want %h", got, exp);
        end
        deliver();
    endtask

    task automatic test_both_zero();
        accept_op(16'h0000, 16'h0000);
        wait_out(lat);
        exp = {16'h0000, 16'h0000, 4'd0, 4'd0, 1'b1, 1'b1, 2'b00};
        assertCount++;
        if (lat !== 1) begin
            failCount++;
            $display("FAIL zero_latency: got %0d, want 1", lat);
        end
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL zero_result: got %h, want %h", got, exp);
        end
        deliver();
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_in      = '0;
        d_in      = '0;
        test_reset();
        test_basic();
        test_max_shift();
        test_div_zero();
        test_back_pressure();
        test_abort();
        test_both_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
